// File: rtl/mem_responder.sv
// Wait-state memory responder: level-signalled rd/wr requests are accepted on
// their rising edge, stretched by WAIT_CYCLES wait states, then acknowledged
// with a one-cycle ready pulse. Requests can be aborted while waiting.
module mem_responder #(
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 5,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          ready,
  output logic          busy,
  output logic          err
);

  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_q, wr_q;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic            op_wr_q, op_wr_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            start_rd_c, start_wr_c;
  logic            abort_c;
  logic            mem_we_c;

  logic [DW-1:0]   mem [0:DEPTH-1];

  assign start_rd_c = rd & ~rd_q;
  assign start_wr_c = wr & ~wr_q;
  // The level belonging to the in-flight operation is the one that may abort it.
  assign abort_c    = op_wr_q ? ~wr : ~rd;

  assign dout  = dout_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

  // Request edge detectors, FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      op_wr_q <= 1'b0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rd_q    <= rd;
      wr_q    <= wr;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      op_wr_q <= op_wr_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic; ready/dout are computed for the edge entering ACK.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    op_wr_d  = op_wr_q;
    dout_d   = dout_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;
    err_d    = 1'b0;
    mem_we_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_rd_c && start_wr_c) begin
          err_d = 1'b1;
        end else if (start_rd_c || start_wr_c) begin
          addr_d  = addr;
          din_d   = din;
          op_wr_d = start_wr_c;
          busy_d  = 1'b1;
          cnt_d   = CW'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = ACK;
            ready_d = 1'b1;
            if (!start_wr_c) dout_d = mem[addr];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (abort_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ACK;
            ready_d = 1'b1;
            if (!op_wr_q) dout_d = mem[addr_q];
          end
        end
      end
      ACK: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        mem_we_c = op_wr_q;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Storage array; contents are deliberately not reset. Writes commit leaving ACK.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[addr_q] <= din_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with two wait states and
// one with none. Stimulus pushes expected (ready cycle, dout) entries; monitors
// pop and compare on every ready pulse.
module tb_mem_responder;

  typedef struct packed {
    int unsigned due;
    logic [7:0]  data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd, wr, rd0, wr0;
  logic [4:0] addr, addr0;
  logic [7:0] din, din0;
  logic [7:0] dout, dout0;
  logic       ready, busy, err, ready0, busy0, err0;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        sb0[$];

  mem_responder #(.DW(8), .AW(5), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .din(din),
    .dout(dout), .ready(ready), .busy(busy), .err(err)
  );

  mem_responder #(.DW(8), .AW(5), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .rd(rd0), .wr(wr0), .addr(addr0), .din(din0),
    .dout(dout0), .ready(ready0), .busy(busy0), .err(err0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ready) begin
      if (sb.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("ready_cycle", cyc, e.due);
        chk("dout", 32'(dout), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ready0) begin
      if (sb0.size() == 0) chk("unexpected_ready0", 32'd1, 32'd0);
      else begin
        e = sb0.pop_front();
        chk("ready_cycle0", cyc, e.due);
        chk("dout0", 32'(dout0), 32'(e.data));
      end
    end
  end

  // Called at a negedge after acceptance: waits for ready, counts busy, drops the request.
  task automatic wait_done(input bit sel, input int exp_busy);
    int  busy_cnt;
    bit  got;
    busy_cnt = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (sel ? busy0 : busy) busy_cnt++;
      if (sel ? ready0 : ready) got = 1;
    end
    chk("ready_seen", 32'(got), 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    if (sel) begin rd0 = 0; wr0 = 0; end else begin rd = 0; wr = 0; end
    @(negedge clk);
    chk("busy_after", 32'(sel ? busy0 : busy), 32'd0);
    chk("ready_after", 32'(sel ? ready0 : ready), 32'd0);
  endtask

  // Full access from a negedge; addr/din are scrambled after acceptance.
  task automatic access(input bit sel, input bit is_wr, input logic [4:0] a,
                        input logic [7:0] d, input logic [7:0] exp_dout);
    int unsigned w;
    w = sel ? 0 : 2;
    if (sel) begin
      addr0 = a; din0 = d;
      if (is_wr) wr0 = 1; else rd0 = 1;
      sb0.push_back('{due: cyc + 1 + w, data: exp_dout});
    end else begin
      addr = a; din = d;
      if (is_wr) wr = 1; else rd = 1;
      sb.push_back('{due: cyc + 1 + w, data: exp_dout});
    end
    @(negedge clk);
    if (sel) begin addr0 = ~a; din0 = ~d; end else begin addr = ~a; din = ~d; end
    wait_done(sel, int'(w) + 1);
  endtask

  // Accept a request, drop it one cycle later while waiting; nothing may complete.
  task automatic abort_req(input bit is_wr, input logic [7:0] d, input logic [7:0] exp_dout);
    addr = 5'd5; din = d;
    if (is_wr) wr = 1; else rd = 1;
    @(negedge clk);
    chk("abort_busy_on", 32'(busy), 32'd1);
    rd = 0; wr = 0;
    @(negedge clk);
    chk("abort_busy_off", 32'(busy), 32'd0);
    chk("abort_no_ready", 32'(ready), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_dout", 32'(dout), 32'(exp_dout));
  endtask

  initial begin
    int pulses;
    rst = 1; rd = 0; wr = 0; addr = '0; din = '0;
    rd0 = 0; wr0 = 0; addr0 = '0; din0 = '0;
    #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_dout0", 32'(dout0), 32'd0);

    // Write then read back with two wait states.
    access(0, 1, 5'd5, 8'hA5, 8'h00);
    access(0, 0, 5'd5, 8'h00, 8'hA5);
    // A different address must not alias.
    access(0, 1, 5'd0, 8'h5A, 8'hA5);
    access(0, 0, 5'd0, 8'h00, 8'h5A);
    access(0, 0, 5'd5, 8'h00, 8'hA5);

    // Zero wait states, top address, read right after the write completes.
    access(1, 1, 5'd31, 8'h3C, 8'h00);
    access(1, 0, 5'd31, 8'h00, 8'h3C);

    // Aborted read keeps dout; aborted write leaves memory intact.
    abort_req(0, 8'h00, 8'hA5);
    access(0, 0, 5'd0, 8'h00, 8'h5A);
    abort_req(1, 8'h11, 8'h5A);
    access(0, 0, 5'd5, 8'h00, 8'hA5);

    // Collision: both levels rise together.
    addr = 5'd5; din = 8'h22; rd = 1; wr = 1;
    @(negedge clk);
    chk("coll_err", 32'(err), 32'd1);
    chk("coll_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("coll_err_pulse", 32'(err), 32'd0);
    chk("coll_busy2", 32'(busy), 32'd0);
    rd = 0; wr = 0;
    repeat (3) @(negedge clk);
    access(0, 0, 5'd5, 8'h00, 8'hA5);

    // Held read: one pulse only; a write start while busy is dropped, not queued.
    addr = 5'd5; rd = 1;
    sb.push_back('{due: cyc + 3, data: 8'hA5});
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin wr = 1; din = 8'h77; end
      if (i == 6) wr = 0;
      if (ready) pulses++;
    end
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("held_busy", 32'(busy), 32'd0);
    rd = 0;
    @(negedge clk);
    access(0, 0, 5'd5, 8'h00, 8'hA5);

    // Reset mid-write, then a read held across reset release.
    addr = 5'd5; din = 8'hFF; wr = 1;
    @(negedge clk);
    chk("rstw_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1; wr = 0; rd = 1; addr = 5'd5;
    #1;
    chk("rstw_busy0", 32'(busy), 32'd0);
    chk("rstw_ready0", 32'(ready), 32'd0);
    chk("rstw_err0", 32'(err), 32'd0);
    chk("rstw_dout0", 32'(dout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    sb.push_back('{due: cyc + 3, data: 8'hA5});
    @(negedge clk);
    wait_done(0, 3);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("sb0_empty", 32'(sb0.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
